// File: rtl/serpario_ctrl.sv
// serpario_ctrl: sequencer for daisy-chained 74HC595 output and 74HC165 input expanders.
// Each transfer shifts DATA_W bits out on SER_OUT and in from SER_IN, then strobes STORE.
// Optional build macro SERPARIO_AUTO_REFRESH_EN: self-start a transfer with the last
// accepted output word after REFRESH_CYCLES idle cycles.
module serpario_ctrl #(
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned CLK_DIV        = 4,
   parameter int unsigned REFRESH_CYCLES = 50000
) (
   input  logic              clk_i,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic [DATA_W-1:0] out_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] in_data_o,
   input  logic              SER_IN,
   output logic              SER_OUT,
   output logic              SH_CLK,
   output logic              STORE,
   output logic              OUT_EN
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
   localparam int unsigned BIT_W = $clog2(DATA_W) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_STORE_ST,
      S_DONE
   } state_t;

   state_t            r_state,  w_state_nxt;
   logic [DIV_W-1:0]  r_div,    w_div_nxt;
   logic [BIT_W-1:0]  r_bit,    w_bit_nxt;
   logic [DATA_W-1:0] r_sr,     w_sr_nxt;
   logic [DATA_W-1:0] r_cap,    w_cap_nxt;
   logic [DATA_W-1:0] r_in,     w_in_nxt;
   logic              r_ser,    w_ser_nxt;
   logic              r_sh,     w_sh_nxt;
   logic              r_store,  w_store_nxt;
   logic              r_done,   w_done_nxt;
   logic              r_busy,   w_busy_nxt;
   logic              r_oe_n,   w_oe_n_nxt;
   logic              w_go;
   logic [DATA_W-1:0] w_go_data;

`ifdef SERPARIO_AUTO_REFRESH_EN
   localparam int unsigned IDLE_W = $clog2(REFRESH_CYCLES) + 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(REFRESH_CYCLES - 1);

   logic [IDLE_W-1:0] r_idle, w_idle_nxt;
   logic [DATA_W-1:0] r_last, w_last_nxt;
`else
   logic w_refresh_unused;
   assign w_refresh_unused = (REFRESH_CYCLES < 2);
`endif

   // Next-state and next-output logic for the transfer sequencer
   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_bit_nxt   = r_bit;
      w_sr_nxt    = r_sr;
      w_cap_nxt   = r_cap;
      w_in_nxt    = r_in;
      w_ser_nxt   = r_ser;
      w_sh_nxt    = r_sh;
      w_store_nxt = 1'b0;
      w_done_nxt  = 1'b0;
      w_oe_n_nxt  = r_oe_n;
      w_go        = 1'b0;
      w_go_data   = out_data_i;
`ifdef SERPARIO_AUTO_REFRESH_EN
      w_idle_nxt  = r_idle;
      w_last_nxt  = r_last;
`endif

      unique case (r_state)
         S_IDLE: begin
`ifdef SERPARIO_AUTO_REFRESH_EN
            // An explicit start wins over a refresh due in the same cycle
            if (start_i) begin
               w_go       = 1'b1;
               w_go_data  = out_data_i;
               w_idle_nxt = '0;
            end else if (r_idle == IDLE_LAST) begin
               w_go       = 1'b1;
               w_go_data  = r_last;
               w_idle_nxt = '0;
            end else begin
               w_idle_nxt = r_idle + IDLE_W'(1);
            end
            if (w_go) begin
               w_last_nxt = w_go_data;
            end
`else
            w_go = start_i;
`endif
            if (w_go) begin
               w_state_nxt = S_SHIFT;
               w_div_nxt   = '0;
               w_bit_nxt   = '0;
               w_sh_nxt    = 1'b0;
               w_ser_nxt   = w_go_data[DATA_W-1];
               w_sr_nxt    = w_go_data << 1;
            end
         end

         S_SHIFT: begin
            if (r_div == DIV_LAST) begin
               w_div_nxt = '0;
               if (!r_sh) begin
                  // Rising SH_CLK: sample the input chain on the same edge
                  w_sh_nxt  = 1'b1;
                  w_cap_nxt = {r_cap[DATA_W-2:0], SER_IN};
               end else if (r_bit == BIT_LAST) begin
                  w_sh_nxt    = 1'b0;
                  w_store_nxt = 1'b1;
                  w_state_nxt = S_STORE_ST;
               end else begin
                  // Falling SH_CLK: present the next bit, MSB first
                  w_sh_nxt  = 1'b0;
                  w_ser_nxt = r_sr[DATA_W-1];
                  w_sr_nxt  = r_sr << 1;
                  w_bit_nxt = r_bit + BIT_W'(1);
               end
            end else begin
               w_div_nxt = r_div + DIV_W'(1);
            end
         end

         S_STORE_ST: begin
            if (r_div == DIV_LAST) begin
               w_div_nxt   = '0;
               w_done_nxt  = 1'b1;
               w_in_nxt    = r_cap;
               w_oe_n_nxt  = 1'b0;
               w_state_nxt = S_DONE;
            end else begin
               w_store_nxt = 1'b1;
               w_div_nxt   = r_div + DIV_W'(1);
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // State and output registers; reset forces all pins to their safe levels
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_div   <= '0;
         r_bit   <= '0;
         r_sr    <= '0;
         r_cap   <= '0;
         r_in    <= '0;
         r_ser   <= 1'b0;
         r_sh    <= 1'b0;
         r_store <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
         r_oe_n  <= 1'b1;
`ifdef SERPARIO_AUTO_REFRESH_EN
         r_idle  <= '0;
         r_last  <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_div   <= w_div_nxt;
         r_bit   <= w_bit_nxt;
         r_sr    <= w_sr_nxt;
         r_cap   <= w_cap_nxt;
         r_in    <= w_in_nxt;
         r_ser   <= w_ser_nxt;
         r_sh    <= w_sh_nxt;
         r_store <= w_store_nxt;
         r_done  <= w_done_nxt;
         r_busy  <= w_busy_nxt;
         r_oe_n  <= w_oe_n_nxt;
`ifdef SERPARIO_AUTO_REFRESH_EN
         r_idle  <= w_idle_nxt;
         r_last  <= w_last_nxt;
`endif
      end
   end

   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign in_data_o = r_in;
   assign SER_OUT   = r_ser;
   assign SH_CLK    = r_sh;
   assign STORE     = r_store;
   assign OUT_EN    = r_oe_n;

endmodule

// File: tb/tb_serpario_ctrl.sv
// tb_serpario_ctrl: drives serpario_ctrl with directed and random transfers, models the
// external 595/165 chains, and compares every cycle against a transfer-level model.
module tb_serpario_ctrl;

   localparam int unsigned DATA_W         = 16;
   localparam int unsigned CLK_DIV        = 4;
   localparam int          REFRESH_CYCLES = 20;
   localparam int          DIV            = CLK_DIV;
   localparam int          SHIFT_CYC      = DATA_W * 2 * DIV;
   localparam int          LAT            = SHIFT_CYC + DIV + 1;
   localparam logic [DATA_W-1:0] POWERUP  = 16'h5A0F;

   logic              clk_i      = 1'b0;
   logic              reset_n    = 1'b0;
   logic              start_i    = 1'b0;
   logic [DATA_W-1:0] out_data_i = '0;
   logic              busy_o;
   logic              done_o;
   logic [DATA_W-1:0] in_data_o;
   logic              SER_IN;
   logic              SER_OUT;
   logic              SH_CLK;
   logic              STORE;
   logic              OUT_EN;

   serpario_ctrl #(
      .DATA_W         (DATA_W),
      .CLK_DIV        (CLK_DIV),
      .REFRESH_CYCLES (REFRESH_CYCLES)
   ) u_dut (
      .clk_i      (clk_i),
      .reset_n    (reset_n),
      .start_i    (start_i),
      .out_data_i (out_data_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .in_data_o  (in_data_o),
      .SER_IN     (SER_IN),
      .SER_OUT    (SER_OUT),
      .SH_CLK     (SH_CLK),
      .STORE      (STORE),
      .OUT_EN     (OUT_EN)
   );

   always #5 clk_i = ~clk_i;

   // External chips: 165 input chain (DS tied low) and 595 output chain
   logic [DATA_W-1:0] par_in   = 16'h3C96;
   logic [DATA_W-1:0] chain165 = POWERUP;
   logic [DATA_W-1:0] sr595    = '0;
   logic [DATA_W-1:0] latch595 = '0;
   assign SER_IN = chain165[DATA_W-1];

   always @(posedge SH_CLK) begin
      chain165 <= {chain165[DATA_W-2:0], 1'b0};
      sr595    <= {sr595[DATA_W-2:0], SER_OUT};
   end

   always @(posedge STORE) begin
      chain165 <= par_in;
      latch595 <= sr595;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transfer-level model: m_t is the index of the current cycle within a transfer (0 = idle)
   int                m_t        = 0;
   logic [DATA_W-1:0] m_word     = '0;
   logic [DATA_W-1:0] m_snap     = POWERUP;
   logic [DATA_W-1:0] m_next_in  = '0;
   logic [DATA_W-1:0] m_in_exp   = '0;
   logic              m_oe       = 1'b1;
`ifdef SERPARIO_AUTO_REFRESH_EN
   int                m_idle     = 0;
   logic [DATA_W-1:0] m_last     = '0;
`endif

   always @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         // An aborted shift leaves the 165 chain advanced by the SH_CLK rises so far
         if (m_t >= 1 && m_t <= SHIFT_CYC)
            m_snap = m_snap << (((m_t - 1) / DIV + 1) / 2);
         m_t      = 0;
         m_in_exp = '0;
         m_oe     = 1'b1;
`ifdef SERPARIO_AUTO_REFRESH_EN
         m_idle   = 0;
         m_last   = '0;
`endif
      end else if (m_t == 0) begin
         logic              acc;
         logic [DATA_W-1:0] w;
         acc = start_i;
         w   = out_data_i;
`ifdef SERPARIO_AUTO_REFRESH_EN
         if (!start_i) begin
            if (m_idle == REFRESH_CYCLES - 1) begin
               acc = 1'b1;
               w   = m_last;
            end else begin
               m_idle++;
            end
         end
         if (acc) begin
            m_idle = 0;
            m_last = w;
         end
`endif
         if (acc) begin
            m_t       = 1;
            m_word    = w;
            m_next_in = m_snap;
         end
      end else begin
         m_t = (m_t == LAT) ? 0 : m_t + 1;
         if (m_t == SHIFT_CYC + 1) m_snap = par_in;
         if (m_t == LAT) begin
            m_in_exp = m_next_in;
            m_oe     = 1'b0;
         end
      end
   end

   // Per-cycle comparison of every pin against the model
   always @(negedge clk_i) begin
      logic              e_sh;
      logic              e_store;
      logic              e_ser;
      logic              chk_ser;
      logic [DATA_W-1:0] tmp;
      e_sh    = 1'b0;
      e_store = 1'b0;
      e_ser   = 1'b0;
      chk_ser = 1'b0;
      if (m_t >= 1 && m_t <= SHIFT_CYC) begin
         e_sh    = (((m_t - 1) / DIV) % 2) == 1;
         tmp     = m_word << ((m_t - 1) / (2 * DIV));
         e_ser   = tmp[DATA_W-1];
         chk_ser = 1'b1;
      end else if (m_t > SHIFT_CYC && m_t <= SHIFT_CYC + DIV) begin
         e_store = 1'b1;
         e_ser   = m_word[0];
         chk_ser = 1'b1;
      end
      check("busy",    32'(busy_o),    32'(m_t != 0));
      check("done",    32'(done_o),    32'(m_t == LAT));
      check("sh_clk",  32'(SH_CLK),    32'(e_sh));
      check("store",   32'(STORE),     32'(e_store));
      check("out_en",  32'(OUT_EN),    32'(m_oe));
      check("in_data", 32'(in_data_o), 32'(m_in_exp));
      if (chk_ser) check("ser_out", 32'(SER_OUT), 32'(e_ser));
      if (m_t == LAT) check("latch595", 32'(latch595), 32'(m_word));
   end

   // Present a start for one cycle; returns at the negedge of the first busy cycle
   task automatic start_xfer(input logic [DATA_W-1:0] w);
      start_i    = 1'b1;
      out_data_i = w;
      @(negedge clk_i);
      start_i    = 1'b0;
      out_data_i = DATA_W'($urandom);
   endtask

   // Count busy cycles up to and including the done_o cycle, bounded
   task automatic wait_done(output int lat);
      lat = 1;
      while (!done_o && lat < 1000) begin
         @(negedge clk_i);
         lat++;
      end
      if (!done_o) check("done_timeout", 32'(lat), 32'(LAT));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int k;
      logic [DATA_W-1:0] w;

      // Reset values
      repeat (3) @(negedge clk_i);
      check("rst_sh_clk",  32'(SH_CLK),    32'd0);
      check("rst_ser_out", 32'(SER_OUT),   32'd0);
      check("rst_out_en",  32'(OUT_EN),    32'd1);
      check("rst_in_data", 32'(in_data_o), 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_i);

      // First transfer: fixed word, power-up 165 content comes back
      start_xfer(16'hA5C3);
      wait_done(lat);
      check("lat_first",   32'(lat),       32'd133);
      check("in_first",    32'(in_data_o), 32'h5A0F);
      check("latch_first", 32'(latch595),  32'hA5C3);
      check("oe_first",    32'(OUT_EN),    32'd0);
      @(negedge clk_i);

      // Second transfer returns the 165 snapshot; starts while busy are ignored
      start_xfer(DATA_W'($urandom));
      repeat (9) @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (49) @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      k = 0;
      for (int i = 0; i < 250; i++) begin
         if (done_o) begin
            k++;
            if (k == 1) check("in_second", 32'(in_data_o), 32'h3C96);
         end
         @(negedge clk_i);
      end
      check("ignored_starts_dones", 32'(k), 32'd1);

      // Reset during bit 7 of SHIFT
      start_xfer(DATA_W'($urandom));
      repeat (58) @(negedge clk_i);
      #2 reset_n = 1'b0;
      #1;
      check("abort_sh_clk",  32'(SH_CLK),  32'd0);
      check("abort_store",   32'(STORE),   32'd0);
      check("abort_ser_out", 32'(SER_OUT), 32'd0);
      check("abort_out_en",  32'(OUT_EN),  32'd1);
      check("abort_busy",    32'(busy_o),  32'd0);
      @(negedge clk_i);
      @(negedge clk_i);
      reset_n = 1'b1;
      @(negedge clk_i);
      w = DATA_W'($urandom);
      start_xfer(w);
      wait_done(lat);
      check("lat_after_abort",   32'(lat),       32'd133);
      check("in_after_abort",    32'(in_data_o), 32'h4B00);
      check("latch_after_abort", 32'(latch595),  32'(w));
      @(negedge clk_i);

      // start_i held high: back-to-back transfers with a one-cycle gap
      start_i    = 1'b1;
      out_data_i = DATA_W'($urandom);
      k   = 0;
      lat = 0;
      while (k < 3 && lat < 600) begin
         @(negedge clk_i);
         lat++;
         if (done_o) k++;
      end
      start_i = 1'b0;
      check("held_start_dones",  32'(k),   32'd3);
      check("held_start_cycles", 32'(lat), 32'(3 * LAT + 2));
      @(negedge clk_i);

      // Random transfers with random gaps and 165 parallel contents
      for (int i = 0; i < 8; i++) begin
         par_in = DATA_W'($urandom);
         repeat ($urandom_range(0, 5)) @(negedge clk_i);
         start_xfer(DATA_W'($urandom));
         wait_done(lat);
         check("lat_random", 32'(lat), 32'(LAT));
         @(negedge clk_i);
      end

`ifdef SERPARIO_AUTO_REFRESH_EN
      // Automatic refresh resends the last word; an explicit start in the trigger cycle wins
      start_xfer(16'h00FF);
      wait_done(lat);
      lat = 0;
      @(negedge clk_i);
      lat++;
      while (!done_o && lat < 400) begin
         @(negedge clk_i);
         lat++;
      end
      check("refresh_lat",   32'(lat),      32'(REFRESH_CYCLES + LAT));
      check("refresh_latch", 32'(latch595), 32'h00FF);
      repeat (REFRESH_CYCLES) @(negedge clk_i);
      start_xfer(16'h1234);
      wait_done(lat);
      check("refresh_override", 32'(latch595), 32'h1234);
`endif

      repeat (5) @(negedge clk_i);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serpario_ctrl.md
Name: serpario_ctrl

Overview:
- Sequencer for the board's daisy-chained serial/parallel I/O expanders: 74HC595-type output registers and 74HC165-type input registers.
- Drives the external SER_OUT, SH_CLK, STORE and OUT_EN pins and samples SER_IN.
- Offers a start/busy/done handshake and parallel data words to a Wishbone-facing register wrapper on the mico32 platform.
- Each transfer shifts one full output word out and one full input word in simultaneously, then strobes STORE.

Parameters:
- DATA_W, 16, chain length in bits; legal 8..32.
- CLK_DIV, 4, clk_i cycles per SH_CLK half-period; legal >= 1.
- REFRESH_CYCLES, 50000, idle clk_i cycles between automatic transfers; used only with the optional feature; legal >= 2.

Ports:
- clk_i  input  1  platform clock
- reset_n  input  1  asynchronous active-low reset
- start_i  input  1  transfer request; accepted only when busy_o=0
- out_data_i  input  DATA_W  output word; sampled in the accept cycle
- busy_o  output  1  transfer in progress
- done_o  output  1  one-cycle pulse; in_data_o is valid from this cycle
- in_data_o  output  DATA_W  last captured input word
- SER_IN  input  1  serial data from the input chain
- SER_OUT  output  1  serial data to the output chain
- SH_CLK  output  1  shift clock to both chains
- STORE  output  1  high pulse: latches 595 outputs and parallel-loads the 165
- OUT_EN  output  1  active-low 595 output enable

Behaviour:
- Interface: one clock, clk_i. reset_n is asynchronous and active-low.
- Reset (asynchronous, immediate, also mid-transfer):
  - SH_CLK=0, STORE=0, SER_OUT=0, OUT_EN=1, busy_o=0, done_o=0, in_data_o=0.
  - State IDLE; all counters 0; the 595 output latches are left untouched.
- States:
  - IDLE -> SHIFT on accept.
  - SHIFT -> STORE_ST after DATA_W bits.
  - STORE_ST -> DONE after CLK_DIV cycles.
  - DONE -> IDLE after 1 cycle.
- Accept: in the cycle where state=IDLE and start_i=1, out_data_i is loaded into the shift register. busy_o=1 from the next cycle.
- start_i is ignored while busy_o=1; there is no queuing.
- SHIFT timing:
  - Each bit takes 2*CLK_DIV cycles: SH_CLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - SER_OUT is updated at the start of each low phase, MSB first: bit DATA_W-1 is sent first.
  - SER_IN is sampled on the clk_i edge that drives SH_CLK 0->1 and shifted into the capture register LSB-wards. The first sampled bit ends up in in_data_o[DATA_W-1].
- STORE_ST: SH_CLK=0 and STORE=1 for CLK_DIV cycles. SER_OUT holds its last bit.
- DONE:
  - STORE=0, done_o=1, busy_o=1; in_data_o is updated with the captured word in this cycle.
  - On the first DONE after reset, OUT_EN goes to 0 and stays 0 until reset.
  - This keeps the outputs tri-stated until valid data has been latched.
- Latency: busy_o high for exactly DATA_W*2*CLK_DIV + CLK_DIV + 1 cycles (133 cycles at defaults).
- start_i=1 in the DONE cycle is ignored. start_i=1 in the first IDLE cycle after DONE is accepted; the back-to-back gap is one cycle.
- Input coherency: the input word reflects the 165 snapshot taken at the previous transfer's STORE. The first transfer after reset returns the power-up parallel-load content.
- in_data_o changes only in DONE cycles.
- Counters:
  - div counter: $clog2(CLK_DIV)+1 bits, wraps at CLK_DIV-1.
  - bit counter: $clog2(DATA_W)+1 bits.
  - No arithmetic overflow is permitted.

Optional Feature:
- Macro: SERPARIO_AUTO_REFRESH_EN.
- Defined:
  - An idle counter increments each IDLE cycle with start_i=0 and clears on any accept.
  - At REFRESH_CYCLES-1 the block self-starts using the last accepted out_data word; after reset that word is 0.
  - start_i=1 in the same cycle wins and its data is used.
  - Refresh transfers are indistinguishable on busy_o and done_o.
- Undefined: no idle counter; transfers occur only on start_i.

Test Plan:
- Reset, DATA_W=16, CLK_DIV=4, start with out_data_i=16'hA5C3 -> SER_OUT sequence 1010_0101_1100_0011 at each rising SH_CLK; STORE high 4 cycles; done_o at cycle 133 after accept; OUT_EN 1->0 in DONE.
- Model the 165 chain preloaded 16'h3C96, run two transfers -> second done_o shows in_data_o=16'h3C96; first shows the power-up model value.
- Pulse start_i at cycle 10 and cycle 60 of a transfer -> both ignored; exactly one done_o; no glitch on SH_CLK.
- Assert reset_n low at bit 7 of SHIFT -> SH_CLK, STORE and SER_OUT low and OUT_EN high immediately; busy_o=0; a new start after release completes normally.
- start_i held high continuously -> transfers repeat with a one-cycle IDLE gap; done_o count equals transfer count.
- With SERPARIO_AUTO_REFRESH_EN and REFRESH_CYCLES=20 -> after a transfer of 16'h00FF, an automatic transfer resends 16'h00FF 20 idle cycles later; start_i in the trigger cycle sends the new word instead.
